// File: rtl/green_sram_writer_if.sv
// Bus bundle between the green pixel FIFO, the SRAM writer and the framebuffer SRAM write port.
// The master side is the writer: it pops the FIFO and drives the SRAM write strobe, address and data.
interface green_sram_writer_if #(
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8,
    parameter int DATA_W = 4 * PIX_W
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [PIX_W-1:0]  fifo_rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/green_sram_writer.sv
// Packs green pixels from the FIFO into 32-bit words and writes one full frame to the framebuffer SRAM.
// Optional GREEN_WR_FRAME_CNT_EN adds a 16-bit count of completed frames (frame_cnt).
module green_sram_writer #(
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8,
    parameter int DATA_W = 4 * PIX_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic frame_done,
    green_sram_writer_if.master bus
`ifdef GREEN_WR_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int CNT_W = ADDR_W + 3;
    localparam logic [CNT_W-1:0]  FRAME_PIX = {1'b1, {(ADDR_W + 2){1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    issued_q;
    logic [1:0]          lane_q;
    logic                pix_vld_q;
    logic [ADDR_W-1:0]   word_addr_q;
    logic [3*PIX_W-1:0]  lanes_q;
    logic                wr_en_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                rd_en;
    logic                last_write;

    // Pop whenever running, data is available and the frame has not been fully requested yet.
    assign rd_en      = (state_q == RUN) && !bus.fifo_empty && (issued_q < FRAME_PIX);
    assign last_write = wr_en_q && (word_addr_q == LAST_ADDR);

    assign bus.fifo_rd_en = rd_en;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = word_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (last_write) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Pixel packing and write generation; abort drops any partial word and in-flight pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q    <= '0;
            lane_q      <= '0;
            pix_vld_q   <= 1'b0;
            word_addr_q <= '0;
            lanes_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
        end else if (abort) begin
            issued_q    <= '0;
            lane_q      <= '0;
            pix_vld_q   <= 1'b0;
            word_addr_q <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (state_q == IDLE && start) begin
                issued_q    <= '0;
                lane_q      <= '0;
                pix_vld_q   <= 1'b0;
                word_addr_q <= '0;
            end else begin
                pix_vld_q <= rd_en;
                if (rd_en) begin
                    issued_q <= issued_q + 1'b1;
                end
                if (wr_en_q) begin
                    word_addr_q <= word_addr_q + 1'b1;
                end
                if (pix_vld_q) begin
                    lane_q <= lane_q + 1'b1;
                    if (lane_q == 2'd3) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= {bus.fifo_rd_data, lanes_q};
                    end else begin
                        lanes_q[int'(lane_q)*PIX_W +: PIX_W] <= bus.fifo_rd_data;
                    end
                end
            end
        end
    end

`ifdef GREEN_WR_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_green_sram_writer.sv
// Scoreboard bench for green_sram_writer with a small frame (ADDR_W=2): random pixels and FIFO stalls
// feed a queue-based FIFO model; expected words are computed from the pixel list and checked by a monitor.
module tb_green_sram_writer;

    localparam int ADDR_W = 2;
    localparam int PIX_W  = 8;
    localparam int DATA_W = 32;
    localparam int WORDS  = 1 << ADDR_W;
    localparam int PIXELS = 4 * WORDS;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic frame_done;
`ifdef GREEN_WR_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    green_sram_writer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DATA_W(DATA_W)) bus ();

    green_sram_writer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus.master)
`ifdef GREEN_WR_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   pops = 0;
    int   start_cycle = 0;
    int   last_wr_cycle = -1;
    int   frames_done_seen = 0;
    int   frames_expected = 0;
    bit   stall_en = 1'b0;
    bit   check_timing = 1'b0;
    bit   first_pending = 1'b0;
    bit   prev_last = 1'b0;
    bit   pop_now = 1'b0;
    logic [7:0] fifo_q[$];
    exp_t exp_q[$];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    always @(posedge clk) cycle++;

    // FIFO model: a pop seen during a cycle delivers its data just after the next rising edge.
    always @(negedge clk) pop_now = bus.fifo_rd_en;

    always @(posedge clk) begin
        #1;
        if (pop_now) begin
            if (fifo_q.size() == 0) begin
                check_output("pop_on_empty", 64'd1, 64'd0);
            end else begin
                bus.fifo_rd_data = fifo_q.pop_front();
                pops++;
            end
        end
        bus.fifo_empty = (fifo_q.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
    end

    // Monitor: compares every SRAM write and frame_done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_last = 1'b0;
        end else begin
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_write", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                    check_output("wr_data", 64'(bus.wr_data), 64'(e.data));
                end
                if (check_timing && first_pending) begin
                    check_output("first_write_latency", 64'(cycle - start_cycle), 64'd6);
                end
                if (check_timing && !first_pending && last_wr_cycle >= 0) begin
                    check_output("write_spacing", 64'(cycle - last_wr_cycle), 64'd4);
                end
                first_pending = 1'b0;
                last_wr_cycle = cycle;
            end
            if (frame_done || prev_last) begin
                check_output("frame_done_after_last_write", 64'(frame_done), 64'(prev_last));
            end
            if (frame_done) begin
                frames_done_seen++;
                check_output("wr_addr_wrap_in_done", 64'(bus.wr_addr), 64'd0);
            end
            prev_last = bus.wr_en && (bus.wr_addr == ADDR_W'(WORDS - 1));
        end
    end

    // Loads n_pix pixels into the FIFO model and queues the complete words they form.
    task automatic apply_stimulus(input int n_pix, input bit use_random, input int base);
        logic [7:0] pix [PIXELS];
        exp_t e;
        for (int i = 0; i < n_pix; i++) begin
            pix[i] = use_random ? 8'($urandom) : 8'(base + i);
            fifo_q.push_back(pix[i]);
        end
        for (int w = 0; w < n_pix / 4; w++) begin
            e.addr = ADDR_W'(w);
            e.data = {pix[4*w+3], pix[4*w+2], pix[4*w+1], pix[4*w]};
            exp_q.push_back(e);
        end
        pops = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        start_cycle = cycle;
        first_pending = 1'b1;
        last_wr_cycle = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int seen0;
        int n;
        seen0 = frames_done_seen;
        n = 0;
        while (frames_done_seen == seen0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_output({name, "_frame_done_seen"}, 64'(frames_done_seen != seen0), 64'd1);
        if (frames_done_seen != seen0) frames_expected++;
        repeat (3) @(posedge clk);
        #2;
        check_output({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
        check_output({name, "_pops"}, 64'(pops), 64'(PIXELS));
        check_output({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;

        #12;
        check_output("reset_fifo_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check_output("reset_wr_en", 64'(bus.wr_en), 64'd0);
        check_output("reset_wr_addr", 64'(bus.wr_addr), 64'd0);
        check_output("reset_wr_data", 64'(bus.wr_data), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_frame_done", 64'(frame_done), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Incrementing pixels, FIFO never stalls: exact latency and 4-cycle write spacing.
        apply_stimulus(PIXELS, 1'b0, 0);
        check_timing = 1'b1;
        pulse_start();
        wait_frame("directed");
        check_timing = 1'b0;

        // Random pixels with random FIFO stalls.
        stall_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            apply_stimulus(PIXELS, 1'b1, 0);
            pulse_start();
            wait_frame("random_stall");
        end
        stall_en = 1'b0;

        // Abort after six pixels: only the first complete word may be written.
        apply_stimulus(6, 1'b0, 0);
        pulse_start();
        repeat (20) @(posedge clk);
        #2;
        check_output("abort_pre_words_left", 64'(exp_q.size()), 64'd0);
        check_output("abort_pre_pops", 64'(pops), 64'd6);
        check_output("abort_pre_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_wr_addr", 64'(bus.wr_addr), 64'd0);
        apply_stimulus(PIXELS, 1'b0, 16);
        pulse_start();
        wait_frame("after_abort");

        // A second start while running must be ignored.
        apply_stimulus(PIXELS, 1'b1, 0);
        seen0 = frames_done_seen;
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("start_in_run_busy", 64'(busy), 64'd1);
        wait_frame("start_in_run");
        repeat (30) @(posedge clk);
        check_output("start_in_run_one_done", 64'(frames_done_seen - seen0), 64'd1);

        // Reset mid-frame clears outputs at once and needs a new start.
        apply_stimulus(PIXELS, 1'b1, 0);
        pulse_start();
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("midreset_wr_en", 64'(bus.wr_en), 64'd0);
        check_output("midreset_wr_data", 64'(bus.wr_data), 64'd0);
        check_output("midreset_fifo_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check_output("midreset_busy", 64'(busy), 64'd0);
        fifo_q.delete();
        exp_q.delete();
        frames_expected = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(PIXELS, 1'b1, 0);
        repeat (10) @(posedge clk);
        #2;
        check_output("midreset_no_pops", 64'(pops), 64'd0);
        check_output("midreset_stays_idle", 64'(busy), 64'd0);
        pulse_start();
        wait_frame("after_reset");
        apply_stimulus(PIXELS, 1'b0, 32);
        pulse_start();
        wait_frame("second_after_reset");

`ifdef GREEN_WR_FRAME_CNT_EN
        check_output("frame_cnt", 64'(frame_cnt), 64'(frames_expected));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
